// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 64-bit timer with prescaler and compare interrupt.
// Single-cycle bus slave; reads return combinationally in the request cycle.
module bus_timer #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic [AddressWidth-1:0] addr_i,
  input  logic                    we_i,
  input  logic [DataWidth-1:0]    wdata_i,
  output logic [DataWidth-1:0]    rdata_o,
  output logic                    irq_o
);

  localparam logic [2:0] RegCtrl   = 3'd0;
  localparam logic [2:0] RegPre    = 3'd1;
  localparam logic [2:0] RegTimeLo = 3'd2;
  localparam logic [2:0] RegTimeHi = 3'd3;
  localparam logic [2:0] RegCmpLo  = 3'd4;
  localparam logic [2:0] RegCmpHi  = 3'd5;
  localparam logic [2:0] RegStatus = 3'd6;

  logic        wr;
  logic        rd;
  logic [2:0]  sel;
  logic [31:0] wdata;

  logic        en;
  logic        irq_en;
  logic [15:0] prescale;
  logic [15:0] pcount;
  logic [63:0] mtime;
  logic [63:0] cmp;
  logic        pending;

  logic        tick;
  logic        cmp_hit;
  logic        clr;
  logic [31:0] rdata;

  logic        unused_addr;

  assign wr    = req_i & we_i;
  assign rd    = req_i & ~we_i;
  assign sel   = addr_i[4:2];
  assign wdata = wdata_i[31:0];

  // Only the word index selects a register; other address bits are decoded upstream.
  assign unused_addr = ^{addr_i[AddressWidth-1:5], addr_i[1:0]};

  // A tick fires on the cycle the prescale count reaches the reload value.
  assign tick    = en & (pcount == prescale);
  assign cmp_hit = (mtime >= cmp);
  assign clr     = wr & (sel == RegStatus) & wdata[0];

  // Control bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en     <= 1'b0;
      irq_en <= 1'b0;
    end else if (wr && sel == RegCtrl) begin
      en     <= wdata[0];
      irq_en <= wdata[1];
    end
  end

  // Prescaler: a PRESCALE write restarts the phase; otherwise count while enabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prescale <= 16'd0;
      pcount   <= 16'd0;
    end else if (wr && sel == RegPre) begin
      prescale <= wdata[15:0];
      pcount   <= 16'd0;
    end else if (en) begin
      if (tick) begin
        pcount <= 16'd0;
      end else begin
        pcount <= pcount + 16'd1;
      end
    end
  end

  // Time counter: a software write to either half wins over a tick that cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime <= 64'd0;
    end else if (wr && sel == RegTimeLo) begin
      mtime[31:0] <= wdata;
    end else if (wr && sel == RegTimeHi) begin
      mtime[63:32] <= wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // Compare value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmp <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (wr && sel == RegCmpLo) begin
      cmp[31:0] <= wdata;
    end else if (wr && sel == RegCmpHi) begin
      cmp[63:32] <= wdata;
    end
  end

  // Sticky pending flag; a live compare match overrides a W1C clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending <= 1'b0;
    end else begin
      pending <= cmp_hit | (pending & ~clr);
    end
  end

  assign irq_o = pending & irq_en;

  // Read mux, forced to zero outside a read and while reset is held.
  always_comb begin
    rdata = 32'd0;
    if (rd && !rst_i) begin
      unique case (sel)
        RegCtrl:   rdata = {30'd0, irq_en, en};
        RegPre:    rdata = {16'd0, prescale};
        RegTimeLo: rdata = mtime[31:0];
        RegTimeHi: rdata = mtime[63:32];
        RegCmpLo:  rdata = cmp[31:0];
        RegCmpHi:  rdata = cmp[63:32];
        RegStatus: rdata = {31'd0, pending};
        default:   rdata = 32'd0;
      endcase
    end
  end

  assign rdata_o = DataWidth'(rdata);

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed checks of bus_timer register access, counting,
// compare/interrupt, wrap, write/tick collision and asynchronous reset.
module tb_bus_timer;

  logic        clk;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_tests;
  int n_fail;
  logic [63:0] exp_q[$];

  bus_timer #(.DataWidth(32), .AddressWidth(32)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_i(req),
    .addr_i(addr),
    .we_i(we),
    .wdata_i(wdata),
    .rdata_o(rdata),
    .irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp_pop(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    e = exp_q.pop_front();
    n_tests++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] d);
    req   = 1'b1;
    we    = 1'b1;
    addr  = {27'd0, idx, 2'b00};
    wdata = d;
    @(posedge clk);
    #1;
    req   = 1'b0;
    we    = 1'b0;
    wdata = 32'd0;
  endtask

  task automatic rd(input logic [2:0] idx, input logic [31:0] e, input string tag);
    exp_q.push_back({32'd0, e});
    req  = 1'b1;
    we   = 1'b0;
    addr = {27'd0, idx, 2'b00};
    #1;
    cmp_pop(tag, {32'd0, rdata});
    req  = 1'b0;
  endtask

  task automatic chk_irq(input logic e, input string tag);
    exp_q.push_back({63'd0, e});
    cmp_pop(tag, {63'd0, irq});
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst   = 1'b1;
    req   = 1'b0;
    we    = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;
    step(2);
    chk_irq(1'b0, "irq_in_reset");
    #2;
    rst = 1'b0;
    step(1);

    rd(3'd0, 32'd0, "rst_ctrl");
    rd(3'd1, 32'd0, "rst_pre");
    rd(3'd2, 32'd0, "rst_tlo");
    rd(3'd3, 32'd0, "rst_thi");
    rd(3'd4, 32'hFFFF_FFFF, "rst_clo");
    rd(3'd5, 32'hFFFF_FFFF, "rst_chi");
    rd(3'd6, 32'd0, "rst_stat");
    chk_irq(1'b0, "rst_irq");

    // Free-run with PRESCALE=0.
    wr(3'd0, 32'd1);
    step(10);
    rd(3'd2, 32'd10, "free_10");
    wr(3'd0, 32'd0);
    step(9);
    rd(3'd2, 32'd11, "free_frozen");
    rd(3'd0, 32'd0, "free_ctrl");

    // Prescale by 4.
    wr(3'd2, 32'd0);
    wr(3'd1, 32'd3);
    rd(3'd1, 32'd3, "pre_rd");
    wr(3'd0, 32'd1);
    step(3);
    rd(3'd2, 32'd0, "pre_3");
    step(1);
    rd(3'd2, 32'd1, "pre_4");
    step(36);
    rd(3'd2, 32'd10, "pre_40");
    step(1);
    wr(3'd1, 32'd3);
    step(3);
    rd(3'd2, 32'd10, "pre_restart_hold");
    step(1);
    rd(3'd2, 32'd11, "pre_restart_tick");

    // Compare and interrupt.
    wr(3'd0, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd2, 32'd0);
    wr(3'd3, 32'd0);
    wr(3'd5, 32'd0);
    wr(3'd4, 32'd5);
    wr(3'd6, 32'd1);
    rd(3'd6, 32'd0, "cmp_stat0");
    wr(3'd0, 32'd3);
    for (int k = 0; k < 8; k++) begin
      rd(3'd2, 32'(k), $sformatf("cmp_time%0d", k));
      chk_irq(k >= 6, $sformatf("cmp_irq%0d", k));
      step(1);
    end
    wr(3'd6, 32'd1);
    chk_irq(1'b1, "w1c_live_irq");
    rd(3'd6, 32'd1, "w1c_live_stat");
    wr(3'd5, 32'd1);
    wr(3'd6, 32'd1);
    chk_irq(1'b0, "w1c_clr_irq");
    rd(3'd6, 32'd0, "w1c_clr_stat");

    // Write/tick collision.
    wr(3'd0, 32'd0);
    wr(3'd3, 32'h55);
    wr(3'd0, 32'd1);
    wr(3'd2, 32'h100);
    rd(3'd2, 32'h100, "col_lo0");
    rd(3'd3, 32'h55, "col_hi0");
    step(1);
    rd(3'd2, 32'h101, "col_lo1");
    rd(3'd3, 32'h55, "col_hi1");

    // 64-bit wrap with compare at all-ones.
    wr(3'd0, 32'd0);
    wr(3'd5, 32'hFFFF_FFFF);
    wr(3'd4, 32'hFFFF_FFFF);
    wr(3'd3, 32'hFFFF_FFFF);
    wr(3'd2, 32'hFFFF_FFFE);
    wr(3'd6, 32'd1);
    chk_irq(1'b0, "wrap_irq_pre");
    wr(3'd0, 32'd3);
    rd(3'd2, 32'hFFFF_FFFE, "wrap_lo_e0");
    step(1);
    rd(3'd2, 32'hFFFF_FFFF, "wrap_lo_max");
    rd(3'd3, 32'hFFFF_FFFF, "wrap_hi_max");
    chk_irq(1'b0, "wrap_irq_max");
    step(1);
    rd(3'd2, 32'd0, "wrap_lo_0");
    rd(3'd3, 32'd0, "wrap_hi_0");
    chk_irq(1'b1, "wrap_irq_set");
    step(1);
    rd(3'd2, 32'd1, "wrap_lo_1");
    chk_irq(1'b1, "wrap_irq_sticky");

    // Asynchronous reset mid-count with the interrupt high.
    #2;
    rst = 1'b1;
    #1;
    chk_irq(1'b0, "arst_irq_drop");
    rd(3'd4, 32'd0, "arst_rdata0");
    step(2);
    chk_irq(1'b0, "arst_irq_hold");
    #3;
    rst = 1'b0;
    step(1);
    rd(3'd0, 32'd0, "arst_ctrl");
    rd(3'd1, 32'd0, "arst_pre");
    rd(3'd2, 32'd0, "arst_tlo");
    rd(3'd3, 32'd0, "arst_thi");
    step(1);
    rd(3'd4, 32'hFFFF_FFFF, "arst_clo");
    rd(3'd5, 32'hFFFF_FFFF, "arst_chi");
    rd(3'd6, 32'd0, "arst_stat");
    rd(3'd7, 32'd0, "arst_rsvd");
    chk_irq(1'b0, "arst_irq_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

endmodule
